// File: rtl/if_prefetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared definitions for the instruction-fetch prefetch queue.
//   INSTR_BYTES    : fetch stride in bytes (one 32-bit instruction word)
//   DEF_ADDR_W/DATA_W : default address/instruction widths of the front end
//   fetch_entry_t  : {pc, instr} pair as stored in the instruction queue at the
//                    default widths (the top declares the same shape locally at
//                    its own parameterised widths)
// -----------------------------------------------------------------------------
package if_pkg;

    localparam int INSTR_BYTES = 4;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue_if
// Bundles the branch redirect, the instruction-memory request/response channel
// and the IF/ID dequeue handshake of the prefetch queue.
//   master : the prefetch queue's view (drives requests and dequeue data)
//   slave  : the environment's view (memory, branch control, ID stage)
// -----------------------------------------------------------------------------
interface if_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OCC_W  = 3
);

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              im_req_valid;
    logic              im_req_ready;
    logic [ADDR_W-1:0] im_req_addr;
    logic              im_rsp_valid;
    logic [DATA_W-1:0] im_rsp_data;
    logic              deq_valid;
    logic              deq_ready;
    logic [ADDR_W-1:0] deq_pc;
    logic [DATA_W-1:0] deq_instr;
    logic [OCC_W-1:0]  occupancy;

    modport master (
        input  redirect_valid, redirect_pc,
        output im_req_valid, im_req_addr,
        input  im_req_ready,
        input  im_rsp_valid, im_rsp_data,
        output deq_valid, deq_pc, deq_instr, occupancy,
        input  deq_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  im_req_valid, im_req_addr,
        output im_req_ready,
        output im_rsp_valid, im_rsp_data,
        input  deq_valid, deq_pc, deq_instr, occupancy,
        output deq_ready
    );

endinterface

// File: rtl/if_prefetch_queue_pq_fifo.sv
// -----------------------------------------------------------------------------
// pq_fifo
// Synchronous circular FIFO with a synchronous clear.
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : empties the FIFO (wins over push/pop)
//   push/push_data : write; accepted when not full, or when full with a pop
//   pop/pop_data   : read head; pop_data always shows the head entry
//   full/empty/count : fill status
// -----------------------------------------------------------------------------
module pq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign count     = count_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign do_pop_s  = pop & ~empty;
    // A push into a full FIFO is fine as long as the head leaves in the same cycle.
    assign do_push_s = push & (~full | do_pop_s);

    // Pointer and fill-count state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= next_ptr(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the slot is not counted.
    always_ff @(posedge clk) begin
        if (do_push_s & ~clear) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/if_prefetch_queue.sv
// -----------------------------------------------------------------------------
// if_prefetch_queue
// Instruction-fetch front end: issues sequential word fetches to a variable
// latency, in-order instruction memory, buffers returned instructions with
// their PC and hands them to IF/ID over a valid/ready handshake. A redirect
// flushes the buffer and turns every in-flight request into a dropped one.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : if_prefetch_queue_if.master
//              redirect_valid/redirect_pc  : branch/jump taken, new fetch target
//              im_req_valid/ready/addr     : memory fetch request
//              im_rsp_valid/data           : in-order memory response
//              deq_valid/ready/pc/instr    : instruction to ID
//              occupancy                   : valid queue entries
// -----------------------------------------------------------------------------
module if_prefetch_queue
    import if_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                DATA_W    = DEF_DATA_W,
    parameter int                DEPTH     = 4,
    parameter int                MAX_OUTST = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
    input logic                 clk,
    input logic                 rst,
    if_prefetch_queue_if.master bus
);

    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int OUT_W   = $clog2(MAX_OUTST + 1);
    localparam int SUM_W   = OCC_W + 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [OUT_W-1:0]  drop_cnt_r;

    // The tag FIFO holds exactly one PC per in-flight request, so its fill
    // count doubles as the outstanding-request counter.
    logic [OUT_W-1:0]  outstanding_s;
    logic              tag_full_s;
    logic              tag_empty_s;
    logic [ADDR_W-1:0] tag_pc_s;

    logic [OCC_W-1:0]  q_count_s;
    logic              q_full_s;
    logic              q_empty_s;
    entry_t            q_head_s;
    entry_t            q_push_s;

    logic [SUM_W-1:0]  reserved_s;
    logic              req_valid_s;
    logic              req_fire_s;
    logic              rsp_fire_s;
    logic              rsp_keep_s;
    logic              deq_valid_s;
    logic              deq_fire_s;

    // A request reserves a queue slot at issue time, so a response can never
    // find the queue full.
    assign reserved_s  = SUM_W'(q_count_s) + SUM_W'(outstanding_s);
    assign req_valid_s = ~rst & ~bus.redirect_valid & ~tag_full_s & ~q_full_s
                       & (reserved_s < SUM_W'(DEPTH));
    assign req_fire_s  = req_valid_s & bus.im_req_ready;
    // Responses with nothing outstanding are spurious and ignored.
    assign rsp_fire_s  = bus.im_rsp_valid & ~tag_empty_s;
    assign rsp_keep_s  = rsp_fire_s & (drop_cnt_r == {OUT_W{1'b0}}) & ~bus.redirect_valid;
    assign deq_valid_s = ~q_empty_s & ~bus.redirect_valid;
    assign deq_fire_s  = deq_valid_s & bus.deq_ready;
    assign q_push_s    = '{pc: tag_pc_s, instr: bus.im_rsp_data};

    assign bus.im_req_valid = req_valid_s;
    assign bus.im_req_addr  = {fetch_pc_r[ADDR_W-1:2], 2'b00};
    assign bus.deq_valid    = deq_valid_s;
    assign bus.deq_pc       = q_empty_s ? {ADDR_W{1'b0}} : q_head_s.pc;
    assign bus.deq_instr    = q_empty_s ? {DATA_W{1'b0}} : q_head_s.instr;
    assign bus.occupancy    = q_count_s;

    // Fetch PC: redirect target wins, otherwise advance one word per accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_r <= RESET_PC;
        end else if (bus.redirect_valid) begin
            fetch_pc_r <= bus.redirect_pc;
        end else if (req_fire_s) begin
            fetch_pc_r <= fetch_pc_r + ADDR_W'(INSTR_BYTES);
        end else begin
            fetch_pc_r <= fetch_pc_r;
        end
    end

    // Drop counter: on redirect every request still in flight after this cycle
    // is stale (no request issues in a redirect cycle, and a response arriving
    // now is discarded too), so the count becomes the new outstanding total.
    // Taking it from outstanding rather than adding keeps back-to-back
    // redirects from double-counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= {OUT_W{1'b0}};
        end else if (bus.redirect_valid) begin
            drop_cnt_r <= outstanding_s - OUT_W'(rsp_fire_s);
        end else if (rsp_fire_s && (drop_cnt_r != {OUT_W{1'b0}})) begin
            drop_cnt_r <= drop_cnt_r - OUT_W'(1);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    pq_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_OUTST)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (1'b0),
        .push      (req_fire_s),
        .push_data (fetch_pc_r),
        .pop       (rsp_fire_s),
        .pop_data  (tag_pc_s),
        .full      (tag_full_s),
        .empty     (tag_empty_s),
        .count     (outstanding_s)
    );

    pq_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (bus.redirect_valid),
        .push      (rsp_keep_s),
        .push_data (q_push_s),
        .pop       (deq_fire_s),
        .pop_data  (q_head_s),
        .full      (q_full_s),
        .empty     (q_empty_s),
        .count     (q_count_s)
    );

endmodule

// File: tb/tb_if_prefetch_queue.sv
module tb_if_prefetch_queue;

    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 4;
    localparam int MAX_OUTST = 2;
    localparam int OCC_W     = 3;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } sb_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    if_prefetch_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OCC_W(OCC_W)) bus ();

    if_prefetch_queue #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // memory model: in-order responses, each due at a cycle number
    int          cyc = 0;
    int          lat = 1;
    logic [31:0] mem_addr_q[$];
    int          mem_due_q[$];

    // scoreboard of live requests in issue order
    sb_t sb_q[$];

    // reference model state
    logic [31:0] m_pc   = 32'h0;
    int          m_out  = 0;
    int          m_drop = 0;
    int          m_occ  = 0;

    logic        want_first = 1'b0;
    logic [31:0] first_pc   = 32'hFFFF_FFFF;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.im_req_ready   = 1'b0;
        bus.im_rsp_valid   = 1'b0;
        bus.im_rsp_data    = 32'h0;
        bus.deq_ready      = 1'b0;
    endtask

    task automatic model_clear();
        m_pc   = 32'h0;
        m_out  = 0;
        m_drop = 0;
        m_occ  = 0;
        mem_addr_q.delete();
        mem_due_q.delete();
        sb_q.delete();
    endtask

    // one clock: drive inputs, check outputs against the model, advance everything
    task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rdy, input logic dr);
        logic        exp_rqv;
        logic        exp_dqv;
        logic        reqf;
        logic        rspf;
        logic        dqf;
        logic        rsp_v;
        logic [31:0] rsp_d;
        sb_t         e;
        rsp_v = (mem_due_q.size() > 0) && (mem_due_q[0] <= cyc);
        rsp_d = rsp_v ? memf(mem_addr_q[0]) : 32'h0;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.im_req_ready   = rdy;
        bus.im_rsp_valid   = rsp_v;
        bus.im_rsp_data    = rsp_d;
        bus.deq_ready      = dr;
        #1;
        exp_rqv = !rv && (m_out < MAX_OUTST) && (m_occ + m_out < DEPTH);
        exp_dqv = (m_occ != 0) && !rv;
        check_eq("occupancy", 64'(bus.occupancy), 64'(m_occ));
        check_eq("req_valid", 64'(bus.im_req_valid), 64'(exp_rqv));
        check_eq("deq_valid", 64'(bus.deq_valid), 64'(exp_dqv));
        if (exp_rqv) begin
            check_eq("req_addr", 64'(bus.im_req_addr), 64'(m_pc & 32'hFFFF_FFFC));
        end
        reqf = exp_rqv && rdy;
        rspf = rsp_v && (m_out != 0);
        dqf  = exp_dqv && dr;
        if (dqf) begin
            check_eq("deq_expected", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("deq_pc", 64'(bus.deq_pc), 64'(e.pc));
                check_eq("deq_instr", 64'(bus.deq_instr), 64'(e.instr));
                if (want_first) begin
                    first_pc   = bus.deq_pc;
                    want_first = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rsp_v) begin
            mem_addr_q.delete(0);
            mem_due_q.delete(0);
        end
        if (reqf) begin
            mem_addr_q.push_back(m_pc & 32'hFFFF_FFFC);
            mem_due_q.push_back(cyc + lat - 1);
            e.pc    = m_pc;
            e.instr = memf(m_pc & 32'hFFFF_FFFC);
            sb_q.push_back(e);
        end
        if (rv) begin
            m_drop = m_out - int'(rspf);
            m_out  = m_out - int'(rspf);
            m_occ  = 0;
            m_pc   = rpc;
            sb_q.delete();
        end else begin
            if (rspf) begin
                if (m_drop > 0) m_drop--;
                else m_occ++;
            end
            m_out = m_out + int'(reqf) - int'(rspf);
            if (dqf) m_occ--;
            if (reqf) m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic run_until_two_outstanding();
        for (int i = 0; i < 30 && m_out != 2; i++) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a0;
        logic        hit;
        rst = 1'b1;
        idle_inputs();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_occupancy", 64'(bus.occupancy), 64'(0));
        check_eq("rst_req_valid", 64'(bus.im_req_valid), 64'(0));
        check_eq("rst_deq_valid", 64'(bus.deq_valid), 64'(0));
        check_eq("rst_req_addr", 64'(bus.im_req_addr), 64'(0));
        check_eq("rst_deq_pc", 64'(bus.deq_pc), 64'(0));
        rst = 1'b0;

        // 1: single-cycle memory, always ready
        lat = 1;
        want_first = 1'b1;
        repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t1_first_pc", 64'(first_pc), 64'(32'h0));

        // 2: ID stall fills the queue and blocks issue
        repeat (10) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t2_full_occ", 64'(bus.occupancy), 64'(4));
        check_eq("t2_req_blocked", 64'(bus.im_req_valid), 64'(0));
        repeat (15) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // 3: 3-cycle memory, redirect with two requests in flight
        lat = 3;
        run_until_two_outstanding();
        want_first = 1'b1;
        first_pc   = 32'hFFFF_FFFF;
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b1);
        repeat (25) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t3_first_pc", 64'(first_pc), 64'(32'h100));

        // 4: redirect coinciding with a response into a nearly-full queue
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (m_occ == 3 && m_out != 0 && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
                hit        = 1'b1;
                want_first = 1'b1;
                first_pc   = 32'hFFFF_FFFF;
                cycle(1'b1, 32'h0000_0200, 1'b1, 1'b0);
                check_eq("t4_occ_cleared", 64'(bus.occupancy), 64'(0));
            end else begin
                cycle(1'b0, 32'h0, 1'b1, 1'b0);
            end
        end
        check_eq("t4_setup_hit", 64'(hit), 64'(1));
        repeat (25) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t4_first_pc", 64'(first_pc), 64'(32'h200));

        // back-to-back redirects: the last one wins
        run_until_two_outstanding();
        want_first = 1'b1;
        first_pc   = 32'hFFFF_FFFF;
        cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0340, 1'b1, 1'b1);
        repeat (25) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("b2b_first_pc", 64'(first_pc), 64'(32'h340));

        // 5: memory back-pressure holds the address stable
        lat = 2;
        a0  = m_pc & 32'hFFFF_FFFC;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 32'h0, 1'b0, 1'b1);
            check_eq("t5_addr_stable", 64'(bus.im_req_addr), 64'(a0));
        end
        repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);

        // misaligned redirect target: address aligned, PC kept as given
        want_first = 1'b1;
        first_pc   = 32'hFFFF_FFFF;
        cycle(1'b1, 32'h0000_0403, 1'b1, 1'b1);
        check_eq("mis_req_addr", 64'(bus.im_req_addr), 64'(32'h400));
        repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("mis_first_pc", 64'(first_pc), 64'(32'h403));

        // 6: reset mid-stream with two requests in flight
        lat = 3;
        run_until_two_outstanding();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_eq("t6_req_valid", 64'(bus.im_req_valid), 64'(0));
        check_eq("t6_req_addr", 64'(bus.im_req_addr), 64'(0));
        check_eq("t6_deq_valid", 64'(bus.deq_valid), 64'(0));
        check_eq("t6_deq_pc", 64'(bus.deq_pc), 64'(0));
        check_eq("t6_deq_instr", 64'(bus.deq_instr), 64'(0));
        check_eq("t6_occupancy", 64'(bus.occupancy), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        want_first = 1'b1;
        first_pc   = 32'hFFFF_FFFF;
        repeat (20) cycle(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t6_first_pc", 64'(first_pc), 64'(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
